fib_seq_ctrl: RTL
=================

Name: fib_seq_ctrl

Overview:
- Sequencing controller for the Fibonacci datapath: two term registers plus an adder with carry-out.
- Issues a load strobe to seed the datapath, then paced step strobes, one per displayed term.
- Stops at a programmable term count or on adder overflow.
- Sits between the board clock/buttons and the Fibonacci datapath; its status drives LEDs and the 7-segment scanner.

Parameters:
- DIV, 50_000_000, WAIT-phase length in clk cycles (1 s at 50 MHz); benches use 4.
- CNTW, 26, prescaler width; must satisfy 2^CNTW >= DIV.
- IDXW, 5, width of limit and term_idx.

Ports:
- clk  in  1  system clock, rising edge.
- btn  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a sequence.
- pause  in  1  level; freezes pacing while high.
- limit  in  IDXW  number of steps to perform; sampled on accepted start.
- dp_ovf  in  1  datapath adder carry-out for the next a+b; combinational from datapath.
- dp_load  out  1  one-cycle strobe: datapath sets a<=0, b<=1.
- dp_step  out  1  one-cycle strobe: datapath sets a<=b, b<=a+b.
- term_idx  out  IDXW  number of steps completed since last load.
- busy  out  1  high in LOAD, WAIT, STEP.
- done  out  1  high in DONE.
- ovf  out  1  sticky; sequence ended on overflow.

Behaviour:
- Clock and reset: single clock clk. Reset btn is synchronous and active-high, sampled on the clk rising edge.
- Reset values: state=IDLE; dp_load, dp_step, busy, done, ovf = 0; term_idx=0; prescaler=0; latched limit=0.
- Reset priority: btn overrides all inputs. Asserted mid-sequence, the next cycle is IDLE with no strobe.
- FSM states: IDLE, LOAD, WAIT, STEP, DONE.
- IDLE:
  - start=1 -> LOAD.
  - Latch limit.
- LOAD, exactly one cycle:
  - dp_load=1.
  - term_idx<=0, ovf<=0, prescaler<=0.
  - If latched limit==0 -> DONE; else -> WAIT.
- WAIT:
  - If pause=1: prescaler holds, state holds.
  - Else if prescaler==DIV-1: prescaler<=0, -> STEP.
  - Else prescaler+=1.
  - WAIT therefore lasts DIV unpaused cycles.
- STEP, exactly one cycle, pause ignored:
  - If dp_ovf=1: no dp_step, ovf<=1, -> DONE. Datapath keeps its last valid terms.
  - Else: dp_step=1 (Mealy on state and dp_ovf), term_idx+=1.
  - Then -> DONE if term_idx+1==latched limit, else -> WAIT.
- Pacing: unpaused spacing between consecutive dp_step pulses is DIV+1 cycles. The first dp_step comes DIV+1 cycles after dp_load.
- DONE:
  - done=1, busy=0.
  - term_idx and ovf hold.
  - start=1 -> LOAD; this is a restart and re-latches limit.
- start in LOAD, WAIT or STEP is ignored. The limit input is ignored except at an accepted start.
- dp_load and dp_step are never high in the same cycle, and never high outside LOAD/STEP.
- term_idx never wraps: maximum value is 2^IDXW-1, reached only with limit=2^IDXW-1.

Test Plan:
- DIV=4, reset 1 cycle, start with limit=5:
  - dp_load one cycle after start is seen.
  - 5 dp_step pulses spaced exactly 5 cycles, first 5 cycles after dp_load.
  - Then done=1, term_idx=5, ovf=0, busy=0.
- DIV=4, limit=10, dp_ovf forced 1 in the 3rd STEP cycle:
  - Exactly 2 dp_step pulses.
  - Then ovf=1, done=1, term_idx=2; no strobe in the overflow cycle.
- DIV=4, limit=3, pause high for 7 cycles inside the second WAIT:
  - Second dp_step is delayed by exactly 7 cycles.
  - Pulse count stays 3.
- limit=0, start:
  - One dp_load, zero dp_step.
  - done=1 one cycle later, term_idx=0.
- limit=5, btn asserted after 2nd dp_step:
  - Next cycle: IDLE, all outputs 0.
  - No further strobes until a new start, which yields a fresh dp_load.
- Running with limit=6, pulse start again plus limit=2 mid-WAIT:
  - Ignored; run completes with term_idx=6.
  - From DONE, start with limit=2 restarts: dp_load, then 2 steps.

Source files
------------

// File: rtl/fib_seq_ctrl_if.sv
// Control/status bundle between the Fibonacci sequencer, its datapath and the front panel.
// The slave side belongs to the sequencer; the master side drives requests and the datapath carry.
interface fib_seq_ctrl_if #(
   parameter int IDXW = 5
);
   logic            start;
   logic            pause;
   logic [IDXW-1:0] limit;
   logic            dp_ovf;
   logic            dp_load;
   logic            dp_step;
   logic [IDXW-1:0] term_idx;
   logic            busy;
   logic            done;
   logic            ovf;

   modport master (
      output start, pause, limit, dp_ovf,
      input  dp_load, dp_step, term_idx, busy, done, ovf
   );

   modport slave (
      input  start, pause, limit, dp_ovf,
      output dp_load, dp_step, term_idx, busy, done, ovf
   );
endinterface

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencer: seeds the datapath, then paces one step per DIV+1 clocks until the
// latched term count is reached or the datapath adder would carry out.
module fib_seq_ctrl #(
   parameter int DIV  = 50_000_000,
   parameter int CNTW = 26,
   parameter int IDXW = 5
) (
   input  logic          clk,
   input  logic          btn,
   fib_seq_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_STEP,
      S_DONE
   } state_t;

   localparam logic [CNTW-1:0] PRESC_LAST = CNTW'(DIV - 1);

   state_t          r_state;
   state_t          w_state_next;
   logic [CNTW-1:0] r_presc;
   logic [CNTW-1:0] w_presc_next;
   logic [IDXW-1:0] r_limit;
   logic [IDXW-1:0] w_limit_next;
   logic [IDXW-1:0] r_term_idx;
   logic [IDXW-1:0] w_term_idx_next;
   logic [IDXW-1:0] w_term_plus1;
   logic            r_ovf;
   logic            w_ovf_next;
   logic            w_dp_load;
   logic            w_dp_step;

   // Only evaluated in STEP, where r_term_idx < r_limit, so this never wraps.
   assign w_term_plus1 = r_term_idx + IDXW'(1);

   always_ff @(posedge clk) begin
      if (btn) begin
         r_state    <= S_IDLE;
         r_presc    <= '0;
         r_limit    <= '0;
         r_term_idx <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_presc    <= w_presc_next;
         r_limit    <= w_limit_next;
         r_term_idx <= w_term_idx_next;
         r_ovf      <= w_ovf_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_presc_next    = r_presc;
      w_limit_next    = r_limit;
      w_term_idx_next = r_term_idx;
      w_ovf_next      = r_ovf;
      w_dp_load       = 1'b0;
      w_dp_step       = 1'b0;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_limit_next = bus.limit;
               w_state_next = S_LOAD;
            end
         end

         S_LOAD: begin
            w_dp_load       = 1'b1;
            w_term_idx_next = '0;
            w_ovf_next      = 1'b0;
            w_presc_next    = '0;
            w_state_next    = (r_limit == '0) ? S_DONE : S_WAIT;
         end

         S_WAIT: begin
            if (!bus.pause) begin
               if (r_presc == PRESC_LAST) begin
                  w_presc_next = '0;
                  w_state_next = S_STEP;
               end else begin
                  w_presc_next = r_presc + CNTW'(1);
               end
            end
         end

         S_STEP: begin
            // A pending carry ends the run without stepping, so the datapath keeps valid terms.
            if (bus.dp_ovf) begin
               w_ovf_next   = 1'b1;
               w_state_next = S_DONE;
            end else begin
               w_dp_step       = 1'b1;
               w_term_idx_next = w_term_plus1;
               w_state_next    = (w_term_plus1 == r_limit) ? S_DONE : S_WAIT;
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign bus.dp_load  = w_dp_load;
   assign bus.dp_step  = w_dp_step;
   assign bus.term_idx = r_term_idx;
   assign bus.busy     = (r_state == S_LOAD) || (r_state == S_WAIT) || (r_state == S_STEP);
   assign bus.done     = (r_state == S_DONE);
   assign bus.ovf      = r_ovf;
endmodule
